// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - SimpleARM conditional-execution unit: NZCV flag register, condition check, execute->memory write gating
// Optional macro COND_STATS_EN adds saturating executed/squashed instruction counters.
module cond_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [3:0]       cond_i,
  input  logic [1:0]       flag_w_i,
  input  logic [3:0]       alu_flags_i,
  input  logic             pcs_i,
  input  logic             reg_w_i,
  input  logic             mem_w_i,
  input  logic             no_write_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             cond_ex_o,
  output logic             carry_o,
  output logic [3:0]       flags_o,
  output logic             pcs_m_o,
  output logic             reg_w_m_o,
  output logic             mem_w_m_o
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0] exec_cnt_o,
  output logic [CNT_W-1:0] squash_cnt_o
`endif
);

  logic [3:0] flags_q;
  logic       cond_pass;
  logic       accept;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  // Evaluated on stored flags only; no forwarding of alu_flags_i.
  always_comb begin
    cond_pass = 1'b0;
    case (cond_i)
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = !c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = c && !z;
      4'h9: cond_pass = !c || z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z && (n == v);
      4'hD: cond_pass = z || (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign cond_ex_o = valid_i & cond_pass;
  assign accept    = cond_ex_o & !stall_i & !flush_i;
  assign carry_o   = flags_q[1];
  assign flags_o   = flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= 4'h0;
      pcs_m_o   <= 1'b0;
      reg_w_m_o <= 1'b0;
      mem_w_m_o <= 1'b0;
    end else begin
      if (accept) begin
        if (flag_w_i[1]) flags_q[3:2] <= alu_flags_i[3:2];
        if (flag_w_i[0]) flags_q[1:0] <= alu_flags_i[1:0];
      end
      if (flush_i) begin
        pcs_m_o   <= 1'b0;
        reg_w_m_o <= 1'b0;
        mem_w_m_o <= 1'b0;
      end else if (!stall_i) begin
        pcs_m_o   <= pcs_i & cond_ex_o;
        reg_w_m_o <= reg_w_i & cond_ex_o & !no_write_i;
        mem_w_m_o <= mem_w_i & cond_ex_o;
      end
    end
  end

`ifdef COND_STATS_EN
  logic squash;
  assign squash = valid_i & !cond_pass & !stall_i & !flush_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      exec_cnt_o   <= '0;
      squash_cnt_o <= '0;
    end else begin
      if (accept && !(&exec_cnt_o))   exec_cnt_o   <= exec_cnt_o + 1'b1;
      if (squash && !(&squash_cnt_o)) squash_cnt_o <= squash_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - scoreboard bench for cond_unit (directed vectors, hand-computed expectations)
// Define COND_STATS_EN for both RTL and bench to exercise the counters.
module tb_cond_unit;

  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic [3:0] cond_i;
  logic [1:0] flag_w_i;
  logic [3:0] alu_flags_i;
  logic       pcs_i, reg_w_i, mem_w_i, no_write_i, stall_i, flush_i;
  logic       cond_ex_o, carry_o;
  logic [3:0] flags_o;
  logic       pcs_m_o, reg_w_m_o, mem_w_m_o;
`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_cnt_o, squash_cnt_o;
`endif

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .cond_i(cond_i),
    .flag_w_i(flag_w_i), .alu_flags_i(alu_flags_i), .pcs_i(pcs_i),
    .reg_w_i(reg_w_i), .mem_w_i(mem_w_i), .no_write_i(no_write_i),
    .stall_i(stall_i), .flush_i(flush_i), .cond_ex_o(cond_ex_o),
    .carry_o(carry_o), .flags_o(flags_o), .pcs_m_o(pcs_m_o),
    .reg_w_m_o(reg_w_m_o), .mem_w_m_o(mem_w_m_o)
`ifdef COND_STATS_EN
    , .exec_cnt_o(exec_cnt_o), .squash_cnt_o(squash_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] flags;
    logic       pcs;
    logic       rw;
    logic       mw;
  } reg_exp_t;

  typedef struct {
    int id;
    int cex;
  } comb_exp_t;

  reg_exp_t  rq[$];
  comb_exp_t cq[$];
  int checks = 0;
  int errors = 0;
  int step_id = 0;

  task automatic check(input string name, input int id, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, id, act, exp);
    end
  endtask

  // Registered outputs: one-cycle latency, sampled 1 time unit after the edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (rq.size() > 0) begin
      reg_exp_t e;
      e = rq.pop_front();
      check("flags_o",   e.id, flags_o,          e.flags);
      check("carry_o",   e.id, {3'b0, carry_o},  {3'b0, e.flags[1]});
      check("pcs_m_o",   e.id, {3'b0, pcs_m_o},  {3'b0, e.pcs});
      check("reg_w_m_o", e.id, {3'b0, reg_w_m_o}, {3'b0, e.rw});
      check("mem_w_m_o", e.id, {3'b0, mem_w_m_o}, {3'b0, e.mw});
    end
  end

  // Combinational condition result, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (cq.size() > 0) begin
      comb_exp_t c;
      c = cq.pop_front();
      if (c.cex >= 0) check("cond_ex_o", c.id, {3'b0, cond_ex_o}, c.cex[3:0]);
    end
  end

  task automatic step(input logic v, input logic [3:0] cond, input logic [1:0] fw,
                      input logic [3:0] alu, input logic pcs, input logic rw,
                      input logic mw, input logic nw, input logic st, input logic fl,
                      input int cex, input logic [3:0] eflags, input logic epcs,
                      input logic erw, input logic emw);
    reg_exp_t  r;
    comb_exp_t c;
    valid_i = v; cond_i = cond; flag_w_i = fw; alu_flags_i = alu;
    pcs_i = pcs; reg_w_i = rw; mem_w_i = mw; no_write_i = nw;
    stall_i = st; flush_i = fl;
    step_id++;
    c.id = step_id; c.cex = cex;
    r.id = step_id; r.flags = eflags; r.pcs = epcs; r.rw = erw; r.mw = emw;
    cq.push_back(c);
    rq.push_back(r);
    @(posedge clk);
    #3;
  endtask

  initial begin
    reset = 1'b1;
    valid_i = 0; cond_i = 0; flag_w_i = 0; alu_flags_i = 0;
    pcs_i = 0; reg_w_i = 0; mem_w_i = 0; no_write_i = 0; stall_i = 0; flush_i = 0;
    @(posedge clk);
    #3;
    //   v  cond  fw     alu      pcs rw mw nw st fl  cex  flags   p  r  m
    step(1, 4'hE, 2'b11, 4'b1111, 1, 1, 1, 0, 1, 0,  -1, 4'b0000, 0, 0, 0);
    step(0, 4'h0, 2'b10, 4'b1010, 0, 1, 0, 1, 0, 1,  -1, 4'b0000, 0, 0, 0);
    reset = 1'b0;
    step(1, 4'hE, 2'b11, 4'b0100, 0, 0, 0, 0, 0, 0,   1, 4'b0100, 0, 0, 0);
    step(1, 4'h0, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0,   1, 4'b0100, 0, 1, 0);
    step(1, 4'hE, 2'b11, 4'b1010, 0, 0, 0, 0, 0, 0,   1, 4'b1010, 0, 0, 0);
    step(1, 4'hE, 2'b10, 4'b0101, 0, 0, 0, 0, 0, 0,   1, 4'b0110, 0, 0, 0);
    step(1, 4'hE, 2'b11, 4'b0000, 0, 0, 0, 0, 0, 0,   1, 4'b0000, 0, 0, 0);
    step(1, 4'h0, 2'b11, 4'b1111, 1, 1, 1, 0, 0, 0,   0, 4'b0000, 0, 0, 0);
    step(1, 4'hE, 2'b11, 4'b1000, 0, 0, 0, 0, 0, 0,   1, 4'b1000, 0, 0, 0);
    step(1, 4'hC, 2'b11, 4'b0000, 0, 1, 0, 0, 0, 0,   0, 4'b1000, 0, 0, 0);
    step(1, 4'hA, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0,   0, 4'b1000, 0, 0, 0);
    step(1, 4'hB, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0,   1, 4'b1000, 0, 1, 0);
    step(1, 4'hD, 2'b00, 4'b0000, 0, 1, 1, 0, 0, 0,   1, 4'b1000, 0, 1, 1);
    step(1, 4'hE, 2'b11, 4'b1001, 0, 0, 0, 0, 0, 0,   1, 4'b1001, 0, 0, 0);
    step(1, 4'hA, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0,   1, 4'b1001, 0, 1, 0);
    step(1, 4'hC, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 0,   1, 4'b1001, 1, 0, 0);
    step(1, 4'hF, 2'b11, 4'b0000, 1, 1, 1, 0, 0, 0,   0, 4'b1001, 0, 0, 0);
    step(1, 4'hE, 2'b11, 4'b0100, 0, 0, 0, 0, 0, 0,   1, 4'b0100, 0, 0, 0);
    step(1, 4'h8, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0,   0, 4'b0100, 0, 0, 0);
    step(1, 4'h9, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0,   1, 4'b0100, 0, 1, 0);
    step(0, 4'hE, 2'b11, 4'b1111, 0, 1, 0, 0, 0, 0,   0, 4'b0100, 0, 0, 0);
    // Stall holds outputs and flags, stall+flush bubbles.
    step(1, 4'hE, 2'b00, 4'b0000, 0, 1, 0, 0, 0, 0,   1, 4'b0100, 0, 1, 0);
    step(1, 4'hE, 2'b11, 4'b1111, 0, 0, 0, 0, 1, 0,   1, 4'b0100, 0, 1, 0);
    step(1, 4'hE, 2'b11, 4'b1111, 0, 0, 0, 0, 1, 0,   1, 4'b0100, 0, 1, 0);
    step(1, 4'hE, 2'b11, 4'b1111, 0, 0, 0, 0, 1, 0,   1, 4'b0100, 0, 1, 0);
    step(1, 4'hE, 2'b11, 4'b1111, 0, 1, 0, 0, 1, 1,   1, 4'b0100, 0, 0, 0);
    step(1, 4'hE, 2'b11, 4'b0010, 0, 1, 0, 1, 0, 0,   1, 4'b0010, 0, 0, 0);
    step(1, 4'h2, 2'b00, 4'b0000, 0, 0, 1, 0, 0, 0,   1, 4'b0010, 0, 0, 1);
    step(1, 4'hE, 2'b11, 4'b0000, 0, 1, 0, 0, 0, 1,   1, 4'b0010, 0, 0, 0);
    // ALU result with Z=1 must not affect this same-cycle EQ check.
    step(1, 4'h0, 2'b11, 4'b0100, 0, 1, 0, 0, 0, 0,   0, 4'b0010, 0, 0, 0);
    valid_i = 1'b0; reg_w_i = 1'b0; mem_w_i = 1'b0; pcs_i = 1'b0; flag_w_i = 2'b00;
    begin
      int budget = 20;
      while ((rq.size() > 0 || cq.size() > 0) && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      checks++;
      if (rq.size() > 0 || cq.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d/%0d entries left, expected 0", rq.size(), cq.size());
      end
    end
`ifdef COND_STATS_EN
    checks++;
    if (exec_cnt_o !== 32'd16) begin
      errors++;
      $display("FAIL exec_cnt_o: got %0d expected 16", exec_cnt_o);
    end
    checks++;
    if (squash_cnt_o !== 32'd6) begin
      errors++;
      $display("FAIL squash_cnt_o: got %0d expected 6", squash_cnt_o);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution unit for the SimpleARM execute stage; consumes the NZCV flags produced by the ALU.
- Holds the architectural flag register.
- Evaluates the 4-bit ARM condition field of the instruction in execute against the current flags.
- Gates register-write, memory-write and PC-write controls, registering them into the memory stage.
- Supplies the stored carry back to the ALU carry input for ADC/SBC/RSC.

Parameters:
- CNT_W, 32, width of the optional statistics counters (used only with COND_STATS_EN).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- valid_i  in  1  execute stage holds a real instruction
- cond_i  in  4  instruction condition field [31:28]
- flag_w_i  in  2  [1]: update N,Z; [0]: update C,V (request, before gating)
- alu_flags_i  in  4  ALU flags, [3]=N [2]=Z [1]=C [0]=V
- pcs_i  in  1  instruction writes PC
- reg_w_i  in  1  instruction writes register file
- mem_w_i  in  1  instruction writes memory
- no_write_i  in  1  compare/test op (TST/TEQ/CMP/CMN): suppress reg write
- stall_i  in  1  hold execute→memory boundary
- flush_i  in  1  squash execute→memory boundary
- cond_ex_o  out  1  combinational: condition passes for the current instruction
- carry_o  out  1  stored C flag (flags_q[1]), to ALU carry input
- flags_o  out  4  stored flag register
- pcs_m_o  out  1  registered gated PC write
- reg_w_m_o  out  1  registered gated register write
- mem_w_m_o  out  1  registered gated memory write
- exec_cnt_o  out  CNT_W  executed-instruction count (COND_STATS_EN only)
- squash_cnt_o  out  CNT_W  condition-failed count (COND_STATS_EN only)

Behaviour:
- Reset (sync, high): flags_q=0; pcs_m_o, reg_w_m_o, mem_w_m_o = 0; counters = 0. Reset takes precedence over stall and flush.
- Condition evaluation, combinational on flags_q (N,Z,C,V):
  - 0 EQ: Z; 1 NE: !Z; 2 CS: C; 3 CC: !C
  - 4 MI: N; 5 PL: !N; 6 VS: V; 7 VC: !V
  - 8 HI: C&!Z; 9 LS: !C|Z
  - A GE: N==V; B LT: N!=V
  - C GT: !Z&(N==V); D LE: Z|(N!=V)
  - E AL: 1; F NV: 0 (never executes)
- cond_ex_o = valid_i & cond_pass.
- Accept = cond_ex_o & !stall_i & !flush_i.
- Flag update at edge when Accept:
  - flag_w_i[1]=1: flags_q[3:2] <= alu_flags_i[3:2]
  - flag_w_i[0]=1: flags_q[1:0] <= alu_flags_i[1:0]
  - Fields not selected hold their value.
- Output register, one-cycle latency (execute → memory):
  - stall_i=1, flush_i=0: all outputs and flags hold.
  - flush_i=1 (with or without stall): outputs <= 0 (bubble); flags not updated.
  - Otherwise: pcs_m_o <= pcs_i & cond_ex_o; reg_w_m_o <= reg_w_i & cond_ex_o & !no_write_i; mem_w_m_o <= mem_w_i & cond_ex_o.
- valid_i=0 behaves as a failed condition: bubble, no flag update.
- Back-to-back flag producer/consumer: the consumer in cycle t+1 sees flags written at the end of cycle t. No bypass of alu_flags_i into the condition check in the same cycle.
- carry_o always reflects flags_q[1]; it never reflects the current alu_flags_i.

Optional Feature:
- Macro COND_STATS_EN.
- Defined:
  - exec_cnt_o increments on each Accept.
  - squash_cnt_o increments when valid_i & !cond_pass & !stall_i & !flush_i.
  - Both saturate at all-ones; both clear on reset.
- Undefined: both counter ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset 2 cycles with inputs toggling → flags_o=4'h0, all *_m_o=0, counters 0.
- Flag write: cond=E, flag_w=2'b11, alu_flags=4'b0100, valid → next cycle flags_o=4'b0100. Then cond=0 (EQ), reg_w=1 → cond_ex_o=1, reg_w_m_o=1 one cycle later.
- Partial update: flags_q=4'b1010, cond=E, flag_w=2'b10, alu_flags=4'b0101 → flags_o=4'b0110 (C,V kept).
- Failed condition: flags_o=4'b0000, cond=0 (EQ), reg_w=1, mem_w=1, flag_w=2'b11 → cond_ex_o=0, next cycle *_m_o=0, flags unchanged. With COND_STATS_EN, squash_cnt_o=1.
- Signed conditions: flags N=1,V=0 (4'b1000) → GT/GE fail, LT/LE pass. Flags 4'b1001 → GE/GT pass. Cond=F with any flags never executes.
- Stall/flush: valid AL, reg_w=1, stall=1 for 3 cycles → reg_w_m_o holds its prior value, flags unchanged. Then stall=1 and flush=1 together → reg_w_m_o=0 next cycle. Compare op with no_write=1 → reg_w_m_o=0 while flags still update.
